// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side packer: FSM encoding and width helpers.
// The FSM state is exported on a debug port so checkers can bind to it directly.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Width needed to hold an entry count of 0..pack_n inclusive.
  function automatic int cnt_w(input int pack_n);
    return $clog2(pack_n + 1);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter: counts inc cycles up to TIMEOUT and raises hit there.
// With TIMEOUT=0 the counter never moves and hit stays low.
module idle_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_b,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_b) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (TIMEOUT != 0) && (cnt != LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs PACK_N entries into one word and offers it on a
// valid/ready master port, flushing a partial word after TIMEOUT empty cycles.
//
// Handshake: m_data/m_count are meaningful only while m_valid=1; they hold steady
// until the cycle m_valid&m_ready is seen at a rising clk_b edge, which is the
// single transfer point. m_ready while m_valid=0 is ignored.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int PACK_N     = 4,
  parameter int TIMEOUT    = 16,
  localparam int CNT_W     = cnt_w(PACK_N)
) (
  input  logic                         clk_b,
  input  logic                         rst,
  input  logic                         empty,
  input  logic [FIFO_WIDTH-1:0]        dout_b,
  output logic                         ren_b,
  output logic [FIFO_WIDTH*PACK_N-1:0] m_data,
  output logic [CNT_W-1:0]             m_count,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [15:0]                  word_cnt,
  output state_t                       state
);

  state_t                  cur_state;
  state_t                  next_state;
  logic                    pending;
  logic [CNT_W-1:0]        fill;
  logic [CNT_W-1:0]        fill_next;
  logic [CNT_W:0]          occupancy;
  logic [FIFO_WIDTH-1:0]   lanes      [PACK_N];
  logic [FIFO_WIDTH-1:0]   lanes_next [PACK_N];
  logic [FIFO_WIDTH*PACK_N-1:0] word_next;

  logic capture;
  logic full_now;
  logic flush_now;
  logic handshake;
  logic timer_inc;
  logic timer_clr;
  logic timer_hit;

  // Data requested last cycle is on dout_b now; it always lands in lane 'fill'.
  assign capture   = pending;
  assign full_now  = capture && (fill == CNT_W'(PACK_N - 1));
  assign flush_now = (cur_state == ST_FILL) && timer_hit && (fill != '0) && !pending;
  assign handshake = m_valid && m_ready;

  assign occupancy = {1'b0, fill} + {{CNT_W{1'b0}}, pending};
  assign fill_next = fill + {{(CNT_W-1){1'b0}}, capture};

  // A flush decided this cycle takes priority over a read that empty would allow.
  assign ren_b = !rst && !empty && (cur_state != ST_OUT) &&
                 (occupancy < (CNT_W+1)'(PACK_N)) && !flush_now;

  assign timer_inc = (cur_state == ST_FILL) && empty && !pending;
  assign timer_clr = capture || handshake;

  assign state = cur_state;

  idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk_b (clk_b),
    .rst   (rst),
    .inc   (timer_inc),
    .clr   (timer_clr),
    .hit   (timer_hit)
  );

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE: if (ren_b) next_state = ST_FILL;
      ST_FILL: if (full_now || flush_now) next_state = ST_OUT;
      ST_OUT:  if (handshake) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Lane view including the entry captured this cycle, so the word can be
  // registered on the same edge that completes it.
  always_comb begin
    for (int i = 0; i < PACK_N; i++) begin
      lanes_next[i] = lanes[i];
      if (capture && (fill == CNT_W'(i))) begin
        lanes_next[i] = dout_b;
      end
      word_next[i*FIFO_WIDTH +: FIFO_WIDTH] = lanes_next[i];
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst || handshake) begin
      for (int i = 0; i < PACK_N; i++) begin
        lanes[i] <= '0;
      end
      fill <= '0;
    end else begin
      for (int i = 0; i < PACK_N; i++) begin
        lanes[i] <= lanes_next[i];
      end
      fill <= fill_next;
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      pending <= ren_b;
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
    end else if ((cur_state == ST_FILL) && (next_state == ST_OUT)) begin
      m_valid <= 1'b1;
      m_data  <= word_next;
      m_count <= fill_next;
    end else if (handshake) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (handshake) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed FIFO model feeds the DUT, delivered
// words are collected and compared against hand-computed expected words.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  typedef struct {
    string        name;
    int           n;
    logic [95:0]  bytes;
    int           words;
    logic [104:0] exp;
  } vec_t;

  localparam int NV = 6;

  logic       clk_b   = 1'b0;
  logic       rst     = 1'b1;
  logic       empty   = 1'b1;
  logic       m_ready = 1'b1;
  logic       sel     = 1'b0;
  logic [7:0] dout_b  = '0;

  logic        ren_a, ren_z, val_a, val_z;
  logic [31:0] data_a, data_z;
  logic [2:0]  cnt_a, cnt_z;
  logic [15:0] wc_a, wc_z;
  state_t      st_a, st_z;

  logic        ren_s, val_s;
  logic [31:0] data_s;
  logic [2:0]  cnt_s;
  logic [15:0] wc_s;
  state_t      st_s;

  logic [7:0]  src_q[$];
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];
  int          ren_q[$];
  int          hs_q[$];
  logic        rd_prev = 1'b0;
  logic [7:0]  rd_byte = '0;
  int cyc = 0;
  int ren_empty_viol = 0;
  int val_cycles = 0;
  int first_valid_cyc = -1;
  int last_ren_cyc = -1;
  int checks = 0;
  int errors = 0;
  vec_t vecs[NV];

  always #5 clk_b = ~clk_b;

  fifo_rd_packer #(.FIFO_WIDTH(8), .PACK_N(4), .TIMEOUT(16)) dut (
    .clk_b(clk_b), .rst(rst), .empty(empty), .dout_b(dout_b), .ren_b(ren_a),
    .m_data(data_a), .m_count(cnt_a), .m_valid(val_a), .m_ready(m_ready),
    .word_cnt(wc_a), .state(st_a)
  );

  fifo_rd_packer #(.FIFO_WIDTH(8), .PACK_N(4), .TIMEOUT(0)) dut_z (
    .clk_b(clk_b), .rst(rst), .empty(empty), .dout_b(dout_b), .ren_b(ren_z),
    .m_data(data_z), .m_count(cnt_z), .m_valid(val_z), .m_ready(m_ready),
    .word_cnt(wc_z), .state(st_z)
  );

  assign ren_s  = sel ? ren_z  : ren_a;
  assign val_s  = sel ? val_z  : val_a;
  assign data_s = sel ? data_z : data_a;
  assign cnt_s  = sel ? cnt_z  : cnt_a;
  assign wc_s   = sel ? wc_z   : wc_a;
  assign st_s   = sel ? st_z   : st_a;

  function automatic logic [34:0] w(input int c, input logic [31:0] d);
    return {3'(c), d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: FIFO outputs change at the falling edge, DUT is observed
  // just after, and the task returns just after the next rising edge.
  task automatic step();
    @(negedge clk_b);
    cyc++;
    if (rd_prev) dout_b = rd_byte;
    rd_prev = 1'b0;
    empty = (src_q.size() == 0);
    #1;
    if (ren_s) begin
      if (empty) begin
        ren_empty_viol++;
      end else begin
        rd_byte = src_q.pop_front();
        rd_prev = 1'b1;
        ren_q.push_back(cyc);
        last_ren_cyc = cyc;
      end
    end
    if (val_s) begin
      val_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_ready) begin
        got_q.push_back({cnt_s, data_s});
        hs_q.push_back(cyc);
      end
    end
    @(posedge clk_b);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    rd_prev = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    ren_q.delete();
    hs_q.delete();
    val_cycles = 0;
    first_valid_cyc = -1;
    ren_empty_viol = 0;
  endtask

  task automatic drain(input string name, input int nwords, input int budget);
    int n;
    n = 0;
    while ((got_q.size() < nwords) && (n < budget)) begin
      step();
      n++;
    end
    check($sformatf("%s_words", name), 64'(got_q.size()), 64'(nwords));
    for (int i = 0; i < nwords; i++) begin
      if (i < got_q.size()) check($sformatf("%s_word%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic set_vec(input int i, input string name, input int n, input logic [95:0] b,
                         input int words, input logic [104:0] exp);
    vecs[i].name = name;
    vecs[i].n = n;
    vecs[i].bytes = b;
    vecs[i].words = words;
    vecs[i].exp = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int wc_exp;
    int n;
    int r;
    int ren_before;
    logic [31:0] held_data;
    logic [2:0]  held_cnt;
    int held_changes;

    set_vec(0, "full",     4,  96'hD4C3B2A1, 1, {70'h0, w(4, 32'hD4C3B2A1)});
    set_vec(1, "partial",  2,  96'h2211,     1, {70'h0, w(2, 32'h00002211)});
    set_vec(2, "stream12", 12, 96'h0C0B0A09_08070605_04030201, 3,
            {w(4, 32'h0C0B0A09), w(4, 32'h08070605), w(4, 32'h04030201)});
    set_vec(3, "partial3", 3,  96'h776655,   1, {70'h0, w(3, 32'h00776655)});
    set_vec(4, "five",     5,  96'hEE_DDCCBBAA, 2, {35'h0, w(1, 32'h000000EE), w(4, 32'hDDCCBBAA)});
    set_vec(5, "single",   1,  96'h5A,       1, {70'h0, w(1, 32'h0000005A)});

    // Reset with a non-empty FIFO: no reads, all outputs at their reset values.
    clear_sb();
    rst = 1'b1;
    src_q.push_back(8'hFF);
    step();
    step();
    check("rst_no_ren", 64'(ren_q.size()), 0);
    check("rst_m_valid", 64'(val_s), 0);
    check("rst_m_data", 64'(data_s), 0);
    check("rst_m_count", 64'(cnt_s), 0);
    check("rst_word_cnt", 64'(wc_s), 0);
    check("rst_state", 64'(st_s), 64'(ST_IDLE));
    src_q.delete();
    rst = 1'b0;
    wc_exp = 0;

    for (int v = 0; v < NV; v++) begin
      clear_sb();
      for (int i = 0; i < vecs[v].n; i++) src_q.push_back(vecs[v].bytes[8*i +: 8]);
      for (int i = 0; i < vecs[v].words; i++) exp_q.push_back(vecs[v].exp[35*i +: 35]);
      drain(vecs[v].name, vecs[v].words, 200);
      for (int i = 0; i < 40; i++) step();
      check($sformatf("%s_no_extra", vecs[v].name), 64'(got_q.size()), 64'(vecs[v].words));
      check($sformatf("%s_reads", vecs[v].name), 64'(ren_q.size()), 64'(vecs[v].n));
      check($sformatf("%s_ren_empty", vecs[v].name), 64'(ren_empty_viol), 0);
      wc_exp += vecs[v].words;
      check($sformatf("%s_word_cnt", vecs[v].name), 64'(wc_s), 64'(wc_exp));
    end

    // Latency and throughput: two full words back to back with m_ready high.
    clear_sb();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i * 16));
    exp_q.push_back(w(4, 32'h40302010));
    exp_q.push_back(w(4, 32'h80706050));
    drain("lat", 2, 60);
    check("lat_reads", 64'(ren_q.size()), 8);
    if (ren_q.size() >= 4) check("lat_last_read_to_valid", 64'(first_valid_cyc - ren_q[3]), 2);
    if (hs_q.size() >= 2) check("lat_word_period", 64'(hs_q[1] - hs_q[0]), 6);
    check("lat_valid_cycles", 64'(val_cycles), 2);
    wc_exp += 2;
    check("lat_word_cnt", 64'(wc_s), 64'(wc_exp));

    // Timeout flush, with data reappearing exactly when the timer expires.
    clear_sb();
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    n = 0;
    while ((src_q.size() != 0) && (n < 20)) begin
      step();
      n++;
    end
    r = last_ren_cyc;
    n = 0;
    while ((cyc + 1 < r + 18) && (n < 40)) begin
      step();
      n++;
    end
    src_q.push_back(8'h33);
    step();
    check("tmo_flush_wins_no_ren", 64'(last_ren_cyc), 64'(r));
    exp_q.push_back(w(2, 32'h00002211));
    exp_q.push_back(w(1, 32'h00000033));
    drain("tmo", 2, 80);
    check("tmo_latency", 64'(first_valid_cyc - r), 19);
    wc_exp += 2;
    check("tmo_word_cnt", 64'(wc_s), 64'(wc_exp));

    // Backpressure: word held stable, no reads until the handshake.
    clear_sb();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) src_q.push_back(8'hA0 + 8'(i));
    n = 0;
    while (!val_s && (n < 50)) begin
      step();
      n++;
    end
    check("bp_valid_seen", 64'(val_s), 1);
    held_data = data_s;
    held_cnt = cnt_s;
    held_changes = 0;
    ren_before = ren_q.size();
    for (int i = 0; i < 10; i++) begin
      step();
      if ((data_s !== held_data) || (cnt_s !== held_cnt) || !val_s) held_changes++;
    end
    check("bp_hold_stable", 64'(held_changes), 0);
    check("bp_held_data", 64'(held_data), 64'h A3A2A1A0);
    check("bp_held_count", 64'(held_cnt), 4);
    check("bp_no_ren_held", 64'(ren_q.size() - ren_before), 0);
    check("bp_fifo_left", 64'(src_q.size()), 4);
    m_ready = 1'b1;
    exp_q.push_back(w(4, 32'hA3A2A1A0));
    exp_q.push_back(w(4, 32'hA7A6A5A4));
    drain("bp", 2, 60);
    wc_exp += 2;
    check("bp_word_cnt", 64'(wc_s), 64'(wc_exp));

    // Reset the cycle after a read: the in-flight entry is dropped.
    clear_sb();
    src_q.push_back(8'h31);
    src_q.push_back(8'h32);
    src_q.push_back(8'h33);
    src_q.push_back(8'h34);
    n = 0;
    while ((ren_q.size() == 0) && (n < 20)) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstp_m_valid", 64'(val_s), 0);
    check("rstp_word_cnt", 64'(wc_s), 0);
    check("rstp_m_count", 64'(cnt_s), 0);
    check("rstp_m_data", 64'(data_s), 0);
    check("rstp_state", 64'(st_s), 64'(ST_IDLE));
    src_q.push_back(8'h35);
    exp_q.push_back(w(4, 32'h35343332));
    drain("rstp", 1, 40);
    check("rstp_word_cnt_after", 64'(wc_s), 1);

    // TIMEOUT=0 instance: a partial word is never flushed.
    sel = 1'b1;
    do_reset();
    clear_sb();
    src_q.push_back(8'h01);
    src_q.push_back(8'h02);
    src_q.push_back(8'h03);
    for (int i = 0; i < 1000; i++) step();
    check("t0_no_flush", 64'(val_cycles), 0);
    check("t0_state_fill", 64'(st_s), 64'(ST_FILL));
    src_q.push_back(8'h04);
    exp_q.push_back(w(4, 32'h04030201));
    drain("t0", 1, 30);
    check("t0_word_cnt", 64'(wc_s), 1);
    check("t0_ren_empty", 64'(ren_empty_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
